rx_bit_sampler: RTL and testbench
=================================

# rx_bit_sampler

Oversampling timing and bit-recovery stage of the UART receiver, directly upstream of the RX control FSM. It owns the edge counter (oversample ticks within a bit) and the bit counter (bit index within a frame) that the FSM decodes. It also majority-votes three mid-bit samples of RX_IN into one recovered bit, which the start, parity and stop checkers and the deserializer consume.

## Interface
- PRESC_W, 6: width of prescale, edge counter and bit counter.
- CLK_SMP  in  1  receiver oversampling clock.
- RST_SMP  in  1  reset, asynchronous, active-low.
- RX_IN  in  1  serial line, idle high.
- prescale_SMP  in  PRESC_W  oversample ratio; legal values are 8, 16 and 32.
- enable_SMP  in  1  counter enable from the FSM; high for the whole frame.
- data_samp_en_SMP  in  1  sampling enable from the FSM.
- edge_cnt_SMP  out  PRESC_W  tick index within the current bit.
- bit_cnt_SMP  out  PRESC_W  bit index within the frame: start = 0, data = 1..8, then parity/stop.
- sampled_bit_SMP  out  1  majority-voted bit value.
- samp_valid_SMP  out  1  one-cycle pulse when sampled_bit_SMP updates.

## Operation
- Counters, on each CLK_SMP rising edge:
  - enable_SMP = 0: edge_cnt and bit_cnt clear to 0.
  - enable_SMP = 1 and edge_cnt >= prescale-1: edge_cnt wraps to 0 and bit_cnt increments. The >= also covers a prescale reduced mid-count.
  - otherwise, with enable_SMP = 1: edge_cnt increments.
- bit_cnt wraps modulo 2^PRESC_W; this is unreachable in legal frames (at most 11 bits).
- Sample points: H = prescale>>1. Sampling is active only while data_samp_en_SMP = 1.
  - At edge_cnt = H-1, H and H+1, the block captures the line value into s0, s1 and s2.
  - At edge_cnt = H+2, it computes sampled_bit = maj(s0, s1, s2), registers it and pulses samp_valid for one cycle.
- sampled_bit holds its value between updates and does not change when enable_SMP falls.
- data_samp_en_SMP = 0: no captures, no update and no valid pulse. Stored samples keep their values.
- Prescale changes are legal only while enable_SMP = 0. The block does not latch prescale; it must behave consistently with the FSM, which also reads prescale directly.
- Reset mid-frame: all state returns to reset values immediately. There is no partial-bit output.

## Timing
- Reset values:
  - edge_cnt_SMP = 0, bit_cnt_SMP = 0.
  - sampled_bit_SMP = 1, samp_valid_SMP = 0.
  - s0, s1, s2 = 1, and synchronizer flops (if present) = 1.
- The first enabled clock edge moves edge_cnt from 0 to 1. The FSM asserts enable in the same cycle it detects RX_IN = 0, so edge_cnt = k means k ticks since start detection.
- Counters are registered. The FSM sees the new edge_cnt one cycle after the edge that updated it.
- samp_valid is high during the cycle where edge_cnt = H+3. sampled_bit is stable no later than edge_cnt = H+3 ≤ prescale-1, so it is valid when the FSM pulses its check and deserializer enables at prescale-1.
  - Worst case is prescale = 8: H+3 = 7 = prescale-1, and the value is still valid.
- Back-to-back frames: if enable_SMP stays high across the stop-to-start transition, edge_cnt wraps to 0 and bit_cnt continues incrementing. The FSM is responsible for dropping enable between frames.

## Configuration
- RX_SYNC_EN defined: RX_IN passes through a two-flop synchronizer (reset value 1) before sampling.
  - Sample points stay at edge_cnt H-1..H+1 but observe the line two cycles earlier.
  - The recovered value is unchanged for prescale ≥ 8.
- RX_SYNC_EN undefined: RX_IN is sampled directly. This is for synchronous testbenches and when an external synchronizer already exists.
- Counter behaviour is identical in both builds.

## Structure
- Package rx_pkg holds:
  - PRESC_W;
  - sample offset constants (-1, 0, +1, and +2 for the vote);
  - a maj3 function.
  The FSM, checkers and deserializer import the same package.
- One sub-module, rx_sync2 (two-flop synchronizer), is instantiated only under RX_SYNC_EN.
- Counters and the voter stay in this module.

## Test plan
- Reset mid-count: assert RST_SMP low when edge_cnt = 5 and bit_cnt = 3 → both read 0 asynchronously, sampled_bit = 1 and samp_valid = 0 until release.
- Counter wrap: prescale = 8, enable held for 24 cycles → edge_cnt runs 1..7, 0, …; bit_cnt reads 3 after 24 edges; enable dropped → both read 0 on the next edge.
- Majority vote: prescale = 16 with a glitch (line 1, 0, 1 at edge_cnt 7, 8, 9) → sampled_bit = 1, with samp_valid pulsed while edge_cnt = 11. Pattern 0, 0, 1 → sampled_bit = 0.
- Full frame: prescale = 8, frame 0x5A LSB-first with stop bit 1 → per-bit sampled values 0, 0, 1, 0, 1, 1, 0, 1, 0, 1; bit_cnt = 8 at the last data bit.
- Sampling gated: data_samp_en = 0 for one whole bit with the line at 0 → no samp_valid, sampled_bit keeps its previous value of 1.
- RX_SYNC_EN build: prescale = 32, line low from tick 10 to tick 20 → sampled_bit = 0 with valid at edge_cnt = 19; results identical to the unsynchronized build for steady bits.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared constants and helpers for the UART receive path (sampler, FSM, checkers, deserializer).
package rx_pkg;

  localparam int unsigned PRESC_W = 6;

  // Sample offsets relative to the mid-bit point H = prescale>>1
  localparam int SMP_OFS_S0   = -1;
  localparam int SMP_OFS_S1   = 0;
  localparam int SMP_OFS_S2   = 1;
  localparam int SMP_OFS_VOTE = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [PRESC_W-1:0] smp_point(input logic [PRESC_W-1:0] half,
                                                   input int ofs);
    return PRESC_W'(int'(half) + ofs);
  endfunction

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for the serial line; resets to the idle-high level.
module rx_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rx_bit_sampler.sv
// UART RX oversampling counters and 3-sample majority bit recovery.
// Define RX_SYNC_EN to route RX_IN through a two-flop synchronizer first.
module rx_bit_sampler
  import rx_pkg::*;
(
  input  logic               CLK_SMP,
  input  logic               RST_SMP,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] prescale_SMP,
  input  logic               enable_SMP,
  input  logic               data_samp_en_SMP,
  output logic [PRESC_W-1:0] edge_cnt_SMP,
  output logic [PRESC_W-1:0] bit_cnt_SMP,
  output logic               sampled_bit_SMP,
  output logic               samp_valid_SMP
);

  logic               w_rx;
  logic [PRESC_W-1:0] w_half;
  logic [PRESC_W-1:0] w_last;
  logic [PRESC_W-1:0] w_pt_s0;
  logic [PRESC_W-1:0] w_pt_s1;
  logic [PRESC_W-1:0] w_pt_s2;
  logic [PRESC_W-1:0] w_pt_vote;

  logic [PRESC_W-1:0] r_edge_cnt;
  logic [PRESC_W-1:0] r_bit_cnt;
  logic               r_s0;
  logic               r_s1;
  logic               r_s2;
  logic               r_sampled_bit;
  logic               r_samp_valid;

`ifdef RX_SYNC_EN
  rx_sync2 u_sync (
    .i_clk   (CLK_SMP),
    .i_rst_n (RST_SMP),
    .i_d     (RX_IN),
    .o_q     (w_rx)
  );
`else
  assign w_rx = RX_IN;
`endif

  // prescale is read live, matching what the FSM decodes
  assign w_half    = prescale_SMP >> 1;
  assign w_last    = prescale_SMP - PRESC_W'(1);
  assign w_pt_s0   = smp_point(w_half, SMP_OFS_S0);
  assign w_pt_s1   = smp_point(w_half, SMP_OFS_S1);
  assign w_pt_s2   = smp_point(w_half, SMP_OFS_S2);
  assign w_pt_vote = smp_point(w_half, SMP_OFS_VOTE);

  // Edge/bit counters; >= tolerates a prescale lowered mid-count
  always_ff @(posedge CLK_SMP or negedge RST_SMP) begin
    if (!RST_SMP) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!enable_SMP) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (r_edge_cnt >= w_last) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + PRESC_W'(1);
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
    end
  end

  // Mid-bit captures and vote; samples and result hold while sampling is gated
  always_ff @(posedge CLK_SMP or negedge RST_SMP) begin
    if (!RST_SMP) begin
      r_s0          <= 1'b1;
      r_s1          <= 1'b1;
      r_s2          <= 1'b1;
      r_sampled_bit <= 1'b1;
      r_samp_valid  <= 1'b0;
    end else begin
      r_samp_valid <= 1'b0;
      if (data_samp_en_SMP) begin
        if (r_edge_cnt == w_pt_s0) r_s0 <= w_rx;
        if (r_edge_cnt == w_pt_s1) r_s1 <= w_rx;
        if (r_edge_cnt == w_pt_s2) r_s2 <= w_rx;
        if (r_edge_cnt == w_pt_vote) begin
          r_sampled_bit <= maj3(r_s0, r_s1, r_s2);
          r_samp_valid  <= 1'b1;
        end
      end
    end
  end

  assign edge_cnt_SMP    = r_edge_cnt;
  assign bit_cnt_SMP     = r_bit_cnt;
  assign sampled_bit_SMP = r_sampled_bit;
  assign samp_valid_SMP  = r_samp_valid;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Self-checking bench for rx_bit_sampler: scoreboard of expected votes popped on samp_valid.
module tb_rx_bit_sampler;
  import rx_pkg::*;

`ifdef RX_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif

  logic               CLK_SMP = 1'b0;
  logic               RST_SMP;
  logic               RX_IN;
  logic [PRESC_W-1:0] prescale_SMP;
  logic               enable_SMP;
  logic               data_samp_en_SMP;
  logic [PRESC_W-1:0] edge_cnt_SMP;
  logic [PRESC_W-1:0] bit_cnt_SMP;
  logic               sampled_bit_SMP;
  logic               samp_valid_SMP;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit sb_q[$];
  int vbit_q[$];
  bit val_q[$];
  bit line_arr[0:127];
  bit exp_b;
  logic [PRESC_W-1:0] exp_edge;

  rx_bit_sampler dut (
    .CLK_SMP          (CLK_SMP),
    .RST_SMP          (RST_SMP),
    .RX_IN            (RX_IN),
    .prescale_SMP     (prescale_SMP),
    .enable_SMP       (enable_SMP),
    .data_samp_en_SMP (data_samp_en_SMP),
    .edge_cnt_SMP     (edge_cnt_SMP),
    .bit_cnt_SMP      (bit_cnt_SMP),
    .sampled_bit_SMP  (sampled_bit_SMP),
    .samp_valid_SMP   (samp_valid_SMP)
  );

  always #5 CLK_SMP = ~CLK_SMP;

  // Scoreboard monitor: every valid pulse pops one expected vote
  always @(posedge CLK_SMP) begin
    #1;
    if (RST_SMP === 1'b1 && samp_valid_SMP === 1'b1) begin
      pulses++;
      vbit_q.push_back(int'(bit_cnt_SMP));
      val_q.push_back(sampled_bit_SMP);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got pulse with sampled_bit=%0b, none expected", sampled_bit_SMP);
      end else begin
        exp_b = sb_q.pop_front();
        if (sampled_bit_SMP !== exp_b) begin
          errors++;
          $display("FAIL vote_value: got %0b, expected %0b", sampled_bit_SMP, exp_b);
        end
      end
      exp_edge = PRESC_W'((int'(prescale_SMP) / 2) + 3);
      checks++;
      if (edge_cnt_SMP !== exp_edge) begin
        errors++;
        $display("FAIL valid_timing: edge_cnt=%0d at valid, expected %0d", edge_cnt_SMP, exp_edge);
      end
    end
  end

  task automatic fill(input bit v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) line_arr[i] = v;
  endtask

  task automatic cyc();
    @(posedge CLK_SMP);
    #1;
  endtask

  // Drive n ticks of line_arr with enable high; push the expected vote for each observable bit
  task automatic run_seq(input int p, input bit en_samp, input int n);
    int h;
    int ones;
    int idx;
    h = p / 2;
    if (en_samp) begin
      for (int b = 0; b * p + h + 3 <= n; b++) begin
        ones = 0;
        for (int k = -1; k <= 1; k++) begin
          idx = b * p + h + k - SYNC_D;
          ones += (idx < 0) ? 1 : int'(line_arr[idx]);
        end
        sb_q.push_back(ones >= 2);
      end
    end
    prescale_SMP     = PRESC_W'(p);
    enable_SMP       = 1'b1;
    data_samp_en_SMP = en_samp;
    for (int i = 0; i < n; i++) begin
      RX_IN = line_arr[i];
      cyc();
    end
    enable_SMP       = 1'b0;
    data_samp_en_SMP = 1'b0;
    RX_IN            = 1'b1;
    repeat (3) cyc();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing_valid: %0d expected pulses never seen", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    RST_SMP = 1'b0; RX_IN = 1'b1; prescale_SMP = PRESC_W'(8);
    enable_SMP = 1'b0; data_samp_en_SMP = 1'b0;
    repeat (2) cyc();
    checks += 4;
    if (edge_cnt_SMP !== '0)     begin errors++; $display("FAIL rst_edge: got %0d, expected 0", edge_cnt_SMP); end
    if (bit_cnt_SMP !== '0)      begin errors++; $display("FAIL rst_bit: got %0d, expected 0", bit_cnt_SMP); end
    if (sampled_bit_SMP !== 1'b1) begin errors++; $display("FAIL rst_sampled: got %0b, expected 1", sampled_bit_SMP); end
    if (samp_valid_SMP !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %0b, expected 0", samp_valid_SMP); end
    RST_SMP = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid();
    prescale_SMP = PRESC_W'(8); enable_SMP = 1'b1; data_samp_en_SMP = 1'b1; RX_IN = 1'b0;
    repeat (3) sb_q.push_back(1'b0);
    repeat (29) cyc();
    checks += 3;
    if (edge_cnt_SMP !== PRESC_W'(5)) begin errors++; $display("FAIL mid_edge: got %0d, expected 5", edge_cnt_SMP); end
    if (bit_cnt_SMP !== PRESC_W'(3))  begin errors++; $display("FAIL mid_bit: got %0d, expected 3", bit_cnt_SMP); end
    if (sampled_bit_SMP !== 1'b0)     begin errors++; $display("FAIL mid_sampled: got %0b, expected 0", sampled_bit_SMP); end
    #2 RST_SMP = 1'b0;
    #1;
    checks += 3;
    if (edge_cnt_SMP !== '0 || bit_cnt_SMP !== '0) begin
      errors++; $display("FAIL async_rst_cnt: edge=%0d bit=%0d, expected 0/0", edge_cnt_SMP, bit_cnt_SMP);
    end
    if (sampled_bit_SMP !== 1'b1) begin errors++; $display("FAIL async_rst_sampled: got %0b, expected 1", sampled_bit_SMP); end
    if (samp_valid_SMP !== 1'b0)  begin errors++; $display("FAIL async_rst_valid: got %0b, expected 0", samp_valid_SMP); end
    repeat (2) cyc();
    checks++;
    if (edge_cnt_SMP !== '0 || sampled_bit_SMP !== 1'b1 || samp_valid_SMP !== 1'b0) begin
      errors++; $display("FAIL held_rst: edge=%0d sampled=%0b valid=%0b, expected 0/1/0", edge_cnt_SMP, sampled_bit_SMP, samp_valid_SMP);
    end
    enable_SMP = 1'b0; data_samp_en_SMP = 1'b0; RX_IN = 1'b1;
    RST_SMP = 1'b1;
    repeat (3) cyc();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL mid_pulses: %0d pulses missing", sb_q.size()); sb_q.delete(); end
  endtask

  task automatic test_counter_wrap();
    prescale_SMP = PRESC_W'(8); enable_SMP = 1'b1; data_samp_en_SMP = 1'b0; RX_IN = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      cyc();
      checks++;
      if (edge_cnt_SMP !== PRESC_W'(i % 8) || bit_cnt_SMP !== PRESC_W'(i / 8)) begin
        errors++;
        $display("FAIL wrap_step%0d: edge=%0d bit=%0d, expected %0d/%0d", i, edge_cnt_SMP, bit_cnt_SMP, i % 8, i / 8);
      end
    end
    checks++;
    if (bit_cnt_SMP !== PRESC_W'(3)) begin errors++; $display("FAIL wrap_bits: got %0d, expected 3", bit_cnt_SMP); end
    enable_SMP = 1'b0;
    cyc();
    checks++;
    if (edge_cnt_SMP !== '0 || bit_cnt_SMP !== '0) begin
      errors++; $display("FAIL wrap_clear: edge=%0d bit=%0d, expected 0/0", edge_cnt_SMP, bit_cnt_SMP);
    end
    repeat (2) cyc();
  endtask

  task automatic test_majority();
    fill(1'b0, 0, 15);
    line_arr[7] = 1'b1; line_arr[8] = 1'b0; line_arr[9] = 1'b1;
    fill(1'b1, 16, 31);
    line_arr[23] = 1'b0; line_arr[24] = 1'b0; line_arr[25] = 1'b1;
    val_q.delete();
    run_seq(16, 1'b1, 32);
    checks++;
    if (val_q.size() != 2 || val_q[0] !== 1'b1 || val_q[1] !== 1'b0) begin
      errors++; $display("FAIL majority: got %0d votes, expected votes 1,0", val_q.size());
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] data;
    bit exp_v[10] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};
    data = 8'h5A;
    fill(1'b0, 0, 7);
    for (int b = 0; b < 8; b++) fill(data[b], 8 * (b + 1), 8 * (b + 1) + 7);
    fill(1'b1, 72, 79);
    val_q.delete(); vbit_q.delete();
    run_seq(8, 1'b1, 80);
    checks++;
    if (val_q.size() != 10) begin
      errors++; $display("FAIL frame_count: got %0d votes, expected 10", val_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (val_q[i] !== exp_v[i]) begin errors++; $display("FAIL frame_bit%0d: got %0b, expected %0b", i, val_q[i], exp_v[i]); end
      end
      checks++;
      if (vbit_q[8] != 8) begin errors++; $display("FAIL frame_bitcnt: got %0d at last data bit, expected 8", vbit_q[8]); end
    end
  endtask

  task automatic test_gated();
    int p0;
    fill(1'b1, 0, 7);
    run_seq(8, 1'b1, 8);
    p0 = pulses;
    fill(1'b0, 0, 7);
    run_seq(8, 1'b0, 8);
    checks += 2;
    if (pulses != p0) begin errors++; $display("FAIL gated_pulse: got %0d pulses, expected 0", pulses - p0); end
    if (sampled_bit_SMP !== 1'b1) begin errors++; $display("FAIL gated_hold: got %0b, expected 1", sampled_bit_SMP); end
  endtask

  task automatic test_sync_window();
    fill(1'b1, 0, 31);
    fill(1'b0, 10, 20);
    run_seq(32, 1'b1, 32);
    checks++;
    if (sampled_bit_SMP !== 1'b0) begin errors++; $display("FAIL window_vote: got %0b, expected 0", sampled_bit_SMP); end
  endtask

  task automatic test_back_to_back();
    fill(1'b1, 0, 15); fill(1'b0, 16, 31); fill(1'b1, 32, 47);
    vbit_q.delete();
    run_seq(16, 1'b1, 48);
    checks++;
    if (vbit_q.size() != 3 || vbit_q[0] != 0 || vbit_q[1] != 1 || vbit_q[2] != 2) begin
      errors++; $display("FAIL b2b_bitcnt: got %0d pulses, expected bit_cnt 0,1,2", vbit_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_counter_wrap();
    test_majority();
    test_full_frame();
    test_gated();
    test_sync_window();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
